// File: rtl/calc3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc3_pkg
// Description : Shared definitions for the calc3 request agent: field widths,
//               opcode and response codes, the request record and a small
//               population-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package calc3_pkg;

    // Field widths
    localparam int NUM_TAGS = 4;   // fixed by the 2-bit tag field
    localparam int TAG_W    = 2;
    localparam int OP_W     = 4;
    localparam int REG_W    = 4;
    localparam int DATA_W   = 32;
    localparam int RESP_W   = 2;
    localparam int CNT_W    = 3;   // holds 0..NUM_TAGS

    // Command codes
    localparam logic [OP_W-1:0] NOP   = 4'd0;
    localparam logic [OP_W-1:0] ADD   = 4'd1;
    localparam logic [OP_W-1:0] SUB   = 4'd2;
    localparam logic [OP_W-1:0] SHL   = 4'd5;
    localparam logic [OP_W-1:0] SHR   = 4'd6;
    localparam logic [OP_W-1:0] STORE = 4'd9;
    localparam logic [OP_W-1:0] FETCH = 4'd10;
    localparam logic [OP_W-1:0] BZ    = 4'd12;
    localparam logic [OP_W-1:0] BEQ   = 4'd13;

    // Response codes (passed through by the agent, never interpreted)
    localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;
    localparam logic [RESP_W-1:0] RESP_SKIP = 2'd3;

    // One request as driven onto the port (tag carried separately)
    typedef struct packed {
        logic [OP_W-1:0]   cmd;
        logic [REG_W-1:0]  d1;
        logic [REG_W-1:0]  d2;
        logic [REG_W-1:0]  r1;
        logic [DATA_W-1:0] data;
    } calc3_req_t;

    // Number of set bits in a tag vector
    function automatic logic [CNT_W-1:0] count_busy(input logic [NUM_TAGS-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc3_tag_table.sv
`default_nettype none
// ============================================================================
// Module      : calc3_tag_table
// Description : Per-tag bookkeeping for the calc3 request agent. Holds the
//               busy flag, issued opcode, age timer and timeout-pending flag
//               of every tag, and encodes the lowest free tag and the lowest
//               tag with a pending timeout.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_alloc/i_alloc_op - claim the lowest free tag for an opcode
//               i_free/i_free_tag  - release a tag (response or timeout)
//               o_busy, o_op       - per-tag busy flags and saved opcodes
//               o_free_valid/_tag  - lowest free tag
//               o_pend_valid/_tag  - lowest tag whose timeout is pending
// Revision    : 1.0 - initial release
// ============================================================================
module calc3_tag_table
    import calc3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_alloc,
    input  logic [OP_W-1:0]                i_alloc_op,
    input  logic                           i_free,
    input  logic [TAG_W-1:0]               i_free_tag,
    output logic [NUM_TAGS-1:0]            o_busy,
    output logic [NUM_TAGS-1:0][OP_W-1:0]  o_op,
    output logic                           o_free_valid,
    output logic [TAG_W-1:0]               o_free_tag,
    output logic                           o_pend_valid,
    output logic [TAG_W-1:0]               o_pend_tag
);

    localparam int                TMR_W    = 8;   // TIMEOUT_CYCLES <= 255
    localparam logic [TMR_W-1:0]  c_TMO    = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0]  c_TMO_M1 = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  c_ONE    = TMR_W'(1);

    logic [NUM_TAGS-1:0]             busy_q,    busy_d;
    logic [NUM_TAGS-1:0]             pending_q, pending_d;
    logic [NUM_TAGS-1:0][OP_W-1:0]   op_q,      op_d;
    logic [NUM_TAGS-1:0][TMR_W-1:0]  timer_q,   timer_d;

    // Lowest-index encoders: scanning downward lets the lowest match win.
    always_comb begin
        o_free_valid = 1'b0;
        o_free_tag   = '0;
        o_pend_valid = 1'b0;
        o_pend_tag   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                o_free_valid = 1'b1;
                o_free_tag   = TAG_W'(i);
            end
            if (pending_q[i]) begin
                o_pend_valid = 1'b1;
                o_pend_tag   = TAG_W'(i);
            end
        end
    end

    always_comb begin
        busy_d    = busy_q;
        pending_d = pending_q;
        op_d      = op_q;
        timer_d   = timer_q;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (i_free && (i_free_tag == TAG_W'(i))) begin
                busy_d[i]    = 1'b0;
                pending_d[i] = 1'b0;
                timer_d[i]   = '0;
            end else if (busy_q[i]) begin
                // Timer saturates at the limit so a blocked timeout keeps
                // its pending flag without wrapping.
                if (timer_q[i] != c_TMO) begin
                    timer_d[i] = timer_q[i] + c_ONE;
                end
                if (timer_q[i] == c_TMO_M1) begin
                    pending_d[i] = 1'b1;
                end
            end
            // Allocation only ever targets a free tag, so it never collides
            // with a release of the same tag.
            if (i_alloc && (o_free_tag == TAG_W'(i))) begin
                busy_d[i]    = 1'b1;
                pending_d[i] = 1'b0;
                op_d[i]      = i_alloc_op;
                timer_d[i]   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            pending_q <= '0;
            op_q      <= '0;
            timer_q   <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
            op_q      <= op_d;
            timer_q   <= timer_d;
        end
    end

    assign o_busy = busy_q;
    assign o_op   = op_q;

endmodule
`default_nettype wire

// File: rtl/calc3_req_agent.sv
`default_nettype none
// ============================================================================
// Module      : calc3_req_agent
// Description : Initiator-side agent for one calc3 request/response port.
//               Accepts client operations, allocates one of four tags, drives
//               a one-cycle request, matches responses back to their tags,
//               retires tags that time out and flags unexpected responses.
// Ports       : c_clk, reset            - clock, synchronous active-high reset
//               cmd_*                   - client operation (valid/ready)
//               req_*                   - request towards the calc3 port
//               out_resp/out_tag/out_data - response from the calc3 port
//               cpl_*                   - one-cycle completion to the client
//               err_unexpected          - response on a tag not outstanding
//               outstanding             - number of busy tags
// Revision    : 1.0 - initial release
// ============================================================================
module calc3_req_agent
    import calc3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               c_clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [OP_W-1:0]    cmd_op,
    input  logic [REG_W-1:0]   cmd_d1,
    input  logic [REG_W-1:0]   cmd_d2,
    input  logic [REG_W-1:0]   cmd_r1,
    input  logic [DATA_W-1:0]  cmd_data,
    output logic [OP_W-1:0]    req_cmd,
    output logic [REG_W-1:0]   req_d1,
    output logic [REG_W-1:0]   req_d2,
    output logic [REG_W-1:0]   req_r1,
    output logic [DATA_W-1:0]  req_data,
    output logic [TAG_W-1:0]   req_tag,
    input  logic [RESP_W-1:0]  out_resp,
    input  logic [TAG_W-1:0]   out_tag,
    input  logic [DATA_W-1:0]  out_data,
    output logic               cpl_valid,
    output logic [TAG_W-1:0]   cpl_tag,
    output logic [OP_W-1:0]    cpl_op,
    output logic [RESP_W-1:0]  cpl_resp,
    output logic [DATA_W-1:0]  cpl_data,
    output logic               cpl_timeout,
    output logic               err_unexpected,
    output logic [CNT_W-1:0]   outstanding
);

    // Tag table view
    logic [NUM_TAGS-1:0]            w_busy;
    logic [NUM_TAGS-1:0][OP_W-1:0]  w_op;
    logic                           w_free_valid;
    logic [TAG_W-1:0]               w_free_tag;
    logic                           w_pend_valid;
    logic [TAG_W-1:0]               w_pend_tag;

    // Per-cycle decisions
    logic                           w_accept;
    logic                           w_resp_hit;
    logic                           w_resp_miss;
    logic                           w_release;
    logic [TAG_W-1:0]               w_release_tag;

    // Registered outputs
    calc3_req_t                     req_q,            req_d;
    logic [TAG_W-1:0]               req_tag_q,        req_tag_d;
    logic                           cpl_valid_q,      cpl_valid_d;
    logic [TAG_W-1:0]               cpl_tag_q,        cpl_tag_d;
    logic [OP_W-1:0]                cpl_op_q,         cpl_op_d;
    logic [RESP_W-1:0]              cpl_resp_q,       cpl_resp_d;
    logic [DATA_W-1:0]              cpl_data_q,       cpl_data_d;
    logic                           cpl_timeout_q,    cpl_timeout_d;
    logic                           err_unexpected_q, err_unexpected_d;

    assign cmd_ready = !reset && w_free_valid;

    // A NOP is consumed (handshake completes) but allocates nothing.
    assign w_accept    = cmd_valid && cmd_ready && (cmd_op != NOP);
    assign w_resp_hit  = (out_resp != RESP_NONE) &&  w_busy[out_tag];
    assign w_resp_miss = (out_resp != RESP_NONE) && !w_busy[out_tag];

    // A matching response owns the completion slot; a pending timeout only
    // retires when no response is being completed this cycle.
    assign w_release     = w_resp_hit || w_pend_valid;
    assign w_release_tag = w_resp_hit ? out_tag : w_pend_tag;

    calc3_tag_table #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tag_table (
        .clk          (c_clk),
        .rst          (reset),
        .i_alloc      (w_accept),
        .i_alloc_op   (cmd_op),
        .i_free       (w_release),
        .i_free_tag   (w_release_tag),
        .o_busy       (w_busy),
        .o_op         (w_op),
        .o_free_valid (w_free_valid),
        .o_free_tag   (w_free_tag),
        .o_pend_valid (w_pend_valid),
        .o_pend_tag   (w_pend_tag)
    );

    always_comb begin
        req_d            = '0;
        req_tag_d        = '0;
        cpl_valid_d      = 1'b0;
        cpl_tag_d        = '0;
        cpl_op_d         = '0;
        cpl_resp_d       = '0;
        cpl_data_d       = '0;
        cpl_timeout_d    = 1'b0;
        err_unexpected_d = w_resp_miss;

        if (w_accept) begin
            req_d.cmd  = cmd_op;
            req_d.d1   = cmd_d1;
            req_d.d2   = cmd_d2;
            req_d.r1   = cmd_r1;
            req_d.data = cmd_data;
            req_tag_d  = w_free_tag;
        end

        if (w_resp_hit) begin
            cpl_valid_d = 1'b1;
            cpl_tag_d   = out_tag;
            cpl_op_d    = w_op[out_tag];
            cpl_resp_d  = out_resp;
            cpl_data_d  = out_data;
        end else if (w_pend_valid) begin
            cpl_valid_d   = 1'b1;
            cpl_tag_d     = w_pend_tag;
            cpl_op_d      = w_op[w_pend_tag];
            cpl_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            req_q            <= '0;
            req_tag_q        <= '0;
            cpl_valid_q      <= 1'b0;
            cpl_tag_q        <= '0;
            cpl_op_q         <= '0;
            cpl_resp_q       <= '0;
            cpl_data_q       <= '0;
            cpl_timeout_q    <= 1'b0;
            err_unexpected_q <= 1'b0;
        end else begin
            req_q            <= req_d;
            req_tag_q        <= req_tag_d;
            cpl_valid_q      <= cpl_valid_d;
            cpl_tag_q        <= cpl_tag_d;
            cpl_op_q         <= cpl_op_d;
            cpl_resp_q       <= cpl_resp_d;
            cpl_data_q       <= cpl_data_d;
            cpl_timeout_q    <= cpl_timeout_d;
            err_unexpected_q <= err_unexpected_d;
        end
    end

    assign req_cmd        = req_q.cmd;
    assign req_d1         = req_q.d1;
    assign req_d2         = req_q.d2;
    assign req_r1         = req_q.r1;
    assign req_data       = req_q.data;
    assign req_tag        = req_tag_q;
    assign cpl_valid      = cpl_valid_q;
    assign cpl_tag        = cpl_tag_q;
    assign cpl_op         = cpl_op_q;
    assign cpl_resp       = cpl_resp_q;
    assign cpl_data       = cpl_data_q;
    assign cpl_timeout    = cpl_timeout_q;
    assign err_unexpected = err_unexpected_q;

    // Follows the busy bits combinationally, so it moves with them.
    assign outstanding = count_busy(w_busy);

endmodule
`default_nettype wire
